// File: rtl/bcd_display_controller.sv
// Sequential double-dabble binary-to-BCD converter (one bit per clock) with a
// start/busy/done handshake, latched result and four active-low 7-segment drivers.
module bcd_display_controller #(
    parameter int WIDTH         = 10,   // 4..13 so the result fits in four BCD digits
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd_out,
    output logic [0:6]       HEX0,
    output logic [0:6]       HEX1,
    output logic [0:6]       HEX2,
    output logic [0:6]       HEX3
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [15:0]      scratch;
    logic [15:0]      scratch_adj;
    logic [CW-1:0]    count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: defaulting every always_comb output first prevents latch inference.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (count == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
    end

    // Add-3 correction applied to every digit before the shift.
    always_comb begin
        scratch_adj = scratch;
        for (int d = 0; d < 4; d++) begin
            if (scratch[4*d +: 4] >= 4'd5)
                scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            bcd_out   <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin_in;
                        scratch   <= '0;
                        count     <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    {scratch, shift_reg} <= {scratch_adj[14:0], shift_reg, 1'b0};
                    count                <= count - CW'(1);
                end
                DONE:    bcd_out <= scratch;
                default: ;
            endcase
        end
    end

    function automatic logic [0:6] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic blank1, blank2, blank3;

    // A digit blanks only when it and every digit above it are zero.
    always_comb begin
        blank3 = BLANK_LEADING && (bcd_out[15:12] == 4'd0);
        blank2 = blank3 && (bcd_out[11:8] == 4'd0);
        blank1 = blank2 && (bcd_out[7:4] == 4'd0);
        HEX0   = seg7(bcd_out[3:0]);
        HEX1   = blank1 ? 7'b1111111 : seg7(bcd_out[7:4]);
        HEX2   = blank2 ? 7'b1111111 : seg7(bcd_out[11:8]);
        HEX3   = blank3 ? 7'b1111111 : seg7(bcd_out[15:12]);
    end

endmodule

// File: tb/tb_bcd_display_controller.sv
// Directed testbench for bcd_display_controller: three instances cover
// WIDTH=10 with and without blanking, and WIDTH=13.
module tb_bcd_display_controller;

    localparam logic [0:6] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
    localparam logic [0:6] S3 = 7'b0000110, S5 = 7'b0100100, S8 = 7'b0000000;
    localparam logic [0:6] S9 = 7'b0000100, SB = 7'b1111111;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;

    logic [9:0]  bin_a = '0, bin_b = '0;
    logic [12:0] bin_c = '0;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic [15:0] bcd_a, bcd_b, bcd_c;
    logic [0:6]  a0, a1, a2, a3, b0, b1, b2, b3, c0, c1, c2, c3;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    bcd_display_controller #(.WIDTH(10), .BLANK_LEADING(1'b1)) u_a (
        .Clock(Clock), .Resetn(Resetn), .bin_in(bin_a), .start(start_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a),
        .HEX0(a0), .HEX1(a1), .HEX2(a2), .HEX3(a3));

    bcd_display_controller #(.WIDTH(10), .BLANK_LEADING(1'b0)) u_b (
        .Clock(Clock), .Resetn(Resetn), .bin_in(bin_b), .start(start_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
        .HEX0(b0), .HEX1(b1), .HEX2(b2), .HEX3(b3));

    bcd_display_controller #(.WIDTH(13), .BLANK_LEADING(1'b1)) u_c (
        .Clock(Clock), .Resetn(Resetn), .bin_in(bin_c), .start(start_c),
        .busy(busy_c), .done(done_c), .bcd_out(bcd_c),
        .HEX0(c0), .HEX1(c1), .HEX2(c2), .HEX3(c3));

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       get_busy = busy_a;
            1:       get_busy = busy_b;
            default: get_busy = busy_c;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       get_done = done_a;
            1:       get_done = done_b;
            default: get_done = done_c;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Pulse start for one cycle on instance sel, then observe 30 cycles.
    // done_at counts edges after the accepting edge.
    task automatic conv(input int sel, input int v, output int busy_cycles,
                        output int done_at, output int done_pulses);
        case (sel)
            0:       begin bin_a = 10'(v); start_a = 1'b1; end
            1:       begin bin_b = 10'(v); start_b = 1'b1; end
            default: begin bin_c = 13'(v); start_c = 1'b1; end
        endcase
        tick();
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        busy_cycles = 0; done_at = -1; done_pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            if (get_busy(sel)) busy_cycles++;
            if (get_done(sel)) begin
                done_pulses++;
                if (done_at < 0) done_at = i - 1;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        #3;
        tests++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || bcd_a !== 16'h0000) begin
            fails++;
            $display("FAIL reset_a: busy=%b done=%b bcd=%h, expected 0 0 0000", busy_a, done_a, bcd_a);
        end
        tests++;
        if ({a3, a2, a1, a0} !== {SB, SB, SB, S0}) begin
            fails++;
            $display("FAIL reset_hex_blank: got %b %b %b %b, expected %b %b %b %b", a3, a2, a1, a0, SB, SB, SB, S0);
        end
        tests++;
        if ({b3, b2, b1, b0} !== {S0, S0, S0, S0}) begin
            fails++;
            $display("FAIL reset_hex_noblank: got %b %b %b %b, expected all %b", b3, b2, b1, b0, S0);
        end
        tick();
        Resetn = 1'b1;
        tick();
    endtask

    task automatic test_zero();
        int bc, da, dp;
        conv(0, 0, bc, da, dp);
        tests++;
        if (da !== 11 || dp !== 1) begin
            fails++;
            $display("FAIL zero_latency: done_at=%0d pulses=%0d, expected 11 1", da, dp);
        end
        tests++;
        if (bcd_a !== 16'h0000 || {a3, a2, a1, a0} !== {SB, SB, SB, S0}) begin
            fails++;
            $display("FAIL zero_result: bcd=%h hex=%b %b %b %b, expected 0000 blank blank blank %b", bcd_a, a3, a2, a1, a0, S0);
        end
    endtask

    task automatic test_1023();
        int bc, da, dp;
        conv(0, 1023, bc, da, dp);
        tests++;
        if (bc !== 10 || da !== 11 || dp !== 1) begin
            fails++;
            $display("FAIL c1023_timing: busy=%0d done_at=%0d pulses=%0d, expected 10 11 1", bc, da, dp);
        end
        tests++;
        if (bcd_a !== 16'h1023 || {a3, a2, a1, a0} !== {S1, S0, S2, S3}) begin
            fails++;
            $display("FAIL c1023_result: bcd=%h hex=%b %b %b %b, expected 1023 %b %b %b %b", bcd_a, a3, a2, a1, a0, S1, S0, S2, S3);
        end
    endtask

    task automatic test_999();
        int bc, da, dp;
        conv(0, 999, bc, da, dp);
        tests++;
        if (bcd_a !== 16'h0999 || {a3, a2, a1, a0} !== {SB, S9, S9, S9}) begin
            fails++;
            $display("FAIL c999_blank: bcd=%h hex=%b %b %b %b, expected 0999 %b %b %b %b", bcd_a, a3, a2, a1, a0, SB, S9, S9, S9);
        end
        conv(1, 999, bc, da, dp);
        tests++;
        if (bcd_b !== 16'h0999 || {b3, b2, b1, b0} !== {S0, S9, S9, S9} || dp !== 1) begin
            fails++;
            $display("FAIL c999_noblank: bcd=%h hex=%b %b %b %b pulses=%0d, expected 0999 %b %b %b %b 1", bcd_b, b3, b2, b1, b0, dp, S0, S9, S9, S9);
        end
    endtask

    task automatic test_ignore_busy();
        int bc, da, dp;
        bin_a = 10'd1023; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick(); tick(); tick();
        bin_a = 10'd5; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        dp = 0;
        for (int i = 0; i < 30; i++) begin
            if (done_a) dp++;
            tick();
        end
        tests++;
        if (dp !== 1 || bcd_a !== 16'h1023) begin
            fails++;
            $display("FAIL ignore_busy: pulses=%0d bcd=%h, expected 1 1023", dp, bcd_a);
        end
        conv(0, 5, bc, da, dp);
        tests++;
        if (bcd_a !== 16'h0005 || {a3, a2, a1, a0} !== {SB, SB, SB, S5}) begin
            fails++;
            $display("FAIL after_ignore: bcd=%h hex=%b %b %b %b, expected 0005 blank blank blank %b", bcd_a, a3, a2, a1, a0, S5);
        end
    endtask

    task automatic test_reset_mid();
        int bc, da, dp;
        int seen;
        bin_a = 10'd512; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick(); tick(); tick(); tick();
        tests++;
        if (busy_a !== 1'b1) begin
            fails++;
            $display("FAIL mid_busy: busy=%b, expected 1", busy_a);
        end
        Resetn = 1'b0;
        #1;
        tests++;
        if (busy_a !== 1'b0 || bcd_a !== 16'h0000 || done_a !== 1'b0 || a0 !== S0 || a1 !== SB) begin
            fails++;
            $display("FAIL mid_reset: busy=%b bcd=%h done=%b hex0=%b hex1=%b, expected 0 0000 0 %b %b", busy_a, bcd_a, done_a, a0, a1, S0, SB);
        end
        tick(); tick();
        Resetn = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_a || busy_a) seen++;
            tick();
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL no_done_after_reset: busy/done cycles=%0d, expected 0", seen);
        end
        conv(0, 512, bc, da, dp);
        tests++;
        if (bcd_a !== 16'h0512 || dp !== 1) begin
            fails++;
            $display("FAIL c512: bcd=%h pulses=%0d, expected 0512 1", bcd_a, dp);
        end
    endtask

    task automatic test_width13();
        int bc, da, dp;
        conv(2, 8191, bc, da, dp);
        tests++;
        if (bc !== 13 || da !== 14 || dp !== 1) begin
            fails++;
            $display("FAIL w13_timing: busy=%0d done_at=%0d pulses=%0d, expected 13 14 1", bc, da, dp);
        end
        tests++;
        if (bcd_c !== 16'h8191 || {c3, c2, c1, c0} !== {S8, S1, S9, S1}) begin
            fails++;
            $display("FAIL w13_result: bcd=%h hex=%b %b %b %b, expected 8191 %b %b %b %b", bcd_c, c3, c2, c1, c0, S8, S1, S9, S1);
        end
    endtask

    task automatic test_back_to_back();
        int t[$];
        bin_c = 13'd8191; start_c = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (done_c) t.push_back(i);
        end
        start_c = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        tests++;
        if (t.size() !== 3) begin
            fails++;
            $display("FAIL b2b_count: pulses=%0d, expected 3", t.size());
        end else begin
            tests++;
            if (t[0] !== 14 || t[1] - t[0] !== 15 || t[2] - t[1] !== 15) begin
                fails++;
                $display("FAIL b2b_period: pulses at %0d %0d %0d, expected 14 29 44", t[0], t[1], t[2]);
            end
        end
        tests++;
        if (bcd_c !== 16'h8191) begin
            fails++;
            $display("FAIL b2b_result: bcd=%h, expected 8191", bcd_c);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_1023();
        test_999();
        test_ignore_busy();
        test_reset_mid();
        test_width13();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
